// File: rtl/csa_test_sched.sv
// Self-test sequencer for the single-fault-tolerant carry-select adder:
// test pass, fault localisation, spare routing, verify pass, then release.
module csa_test_sched #(
  parameter int NUM_BLK = 4,
  parameter int BLK_W   = 6,
  parameter int PAT_W   = 4,
  parameter int NUM_PAT = 16,
  parameter int SETTLE  = 1
) (
  input  logic                     clk,
  input  logic                     init,
  input  logic                     start,
  input  logic [BLK_W-1:0]         desired_output,
  input  logic [NUM_BLK*BLK_W-1:0] actual_output,
  output logic                     test,
  output logic [PAT_W-1:0]         test_data,
  output logic [2:0]               is,
  output logic [NUM_BLK-1:0]       ss,
  output logic [NUM_BLK-1:0]       fault_map,
  output logic                     busy,
  output logic                     done,
  output logic                     fail
);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_EVAL, S_VERIFY, S_CHECK, S_DONE, S_FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   td_q, td_d;
  logic [2:0]         settle_q, settle_d;
  logic [2:0]         is_q, is_d;
  logic [NUM_BLK-1:0] ss_q, ss_d;
  logic [NUM_BLK-1:0] fm_q, fm_d;
  logic [NUM_BLK-1:0] vm_q, vm_d;
  logic [NUM_BLK-1:0] mism;
  logic               last_settle, last_pat, single_fault;

  // Lowest set bit wins; only used when exactly one bit is set.
  function automatic logic [2:0] first_idx(input logic [NUM_BLK-1:0] m);
    logic [2:0] r;
    r = '0;
    for (int k = NUM_BLK - 1; k >= 0; k--) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_BLK; k++) begin
      mism[k] = (actual_output[k*BLK_W +: BLK_W] != desired_output);
    end
  end

  assign last_settle  = (settle_q == 3'(SETTLE));
  assign last_pat     = (td_q == PAT_W'(NUM_PAT - 1));
  assign single_fault = (fm_q != '0) && ((fm_q & (fm_q - 1'b1)) == '0);

  always_comb begin
    state_d  = state_q;
    td_d     = td_q;
    settle_d = settle_q;
    is_d     = is_q;
    ss_d     = ss_q;
    fm_d     = fm_q;
    vm_d     = vm_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_d  = S_RUN;
          td_d     = '0;
          settle_d = '0;
          is_d     = '0;
          ss_d     = '0;
          fm_d     = '0;
          vm_d     = '0;
        end
      end
      S_RUN, S_VERIFY: begin
        if (last_settle) begin
          settle_d = '0;
          if (state_q == S_RUN) fm_d = fm_q | mism;
          else                  vm_d = vm_q | mism;
          if (last_pat) begin
            td_d    = '0;
            state_d = (state_q == S_RUN) ? S_EVAL : S_CHECK;
          end else begin
            td_d = td_q + 1'b1;
          end
        end else begin
          settle_d = settle_q + 3'd1;
        end
      end
      S_EVAL: begin
        if (fm_q == '0) begin
          state_d = S_DONE;
          is_d    = '0;
          ss_d    = '0;
        end else if (single_fault) begin
          state_d  = S_VERIFY;
          is_d     = first_idx(fm_q) + 3'd1;
          ss_d     = fm_q;
          td_d     = '0;
          settle_d = '0;
          vm_d     = '0;
        end else begin
          state_d = S_FAIL;
          is_d    = '0;
          ss_d    = '0;
        end
      end
      S_CHECK: begin
        // A dirty verify pass means the spare itself is bad: drop the repair.
        if (vm_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FAIL;
          is_d    = '0;
          ss_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q  <= S_IDLE;
      td_q     <= '0;
      settle_q <= '0;
      is_q     <= '0;
      ss_q     <= '0;
      fm_q     <= '0;
      vm_q     <= '0;
    end else begin
      state_q  <= state_d;
      td_q     <= td_d;
      settle_q <= settle_d;
      is_q     <= is_d;
      ss_q     <= ss_d;
      fm_q     <= fm_d;
      vm_q     <= vm_d;
    end
  end

  assign test      = (state_q == S_RUN) || (state_q == S_VERIFY);
  assign busy      = test || (state_q == S_EVAL) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign fail      = (state_q == S_FAIL);
  assign test_data = td_q;
  assign is        = is_q;
  assign ss        = ss_q;
  assign fault_map = fm_q;

endmodule

// File: tb/tb_csa_test_sched.sv
// Bench for csa_test_sched: adder/fault environment, timeline model of the
// expected outputs, per-cycle compare and directed scenario checks.
module tb_csa_test_sched;
  localparam int NUM_BLK = 4;
  localparam int BLK_W   = 6;
  localparam int PAT_W   = 4;
  localparam int NUM_PAT = 16;
  localparam int SETTLE  = 1;

  logic                     clk = 1'b0;
  logic                     init = 1'b1;
  logic                     start = 1'b0;
  logic [BLK_W-1:0]         desired_output;
  logic [NUM_BLK*BLK_W-1:0] actual_output;
  logic                     test, busy, done, fail;
  logic [PAT_W-1:0]         test_data;
  logic [2:0]               is;
  logic [NUM_BLK-1:0]       ss, fault_map;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  csa_test_sched #(
    .NUM_BLK(NUM_BLK), .BLK_W(BLK_W), .PAT_W(PAT_W), .NUM_PAT(NUM_PAT), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .init(init), .start(start),
    .desired_output(desired_output), .actual_output(actual_output),
    .test(test), .test_data(test_data), .is(is), .ss(ss),
    .fault_map(fault_map), .busy(busy), .done(done), .fail(fail)
  );

  always #5 clk = ~clk;

  // Adder environment: per-block fault masks indexed by pattern, a faulty spare,
  // and an optional glitch visible only in the first cycle of each pattern.
  logic [15:0]      blk_bad [NUM_BLK];
  logic [15:0]      spare_bad = '0;
  int               glitch_blk = -1;
  logic [PAT_W-1:0] prev_td = '0;

  initial for (int k = 0; k < NUM_BLK; k++) blk_bad[k] = '0;

  always @(posedge clk) prev_td <= test_data;

  always_comb begin
    logic bad;
    desired_output = {2'b00, test_data} * 6'd3 + 6'd7;
    actual_output  = '0;
    for (int k = 0; k < NUM_BLK; k++) begin
      bad = ss[k] ? spare_bad[test_data] : blk_bad[k][test_data];
      if (glitch_blk == k && prev_td != test_data) bad = 1'b1;
      actual_output[k*BLK_W +: BLK_W] = desired_output ^ (bad ? 6'h21 : 6'h00);
    end
  end

  // Model: t counts edges since the accepting start edge (that edge is t=1);
  // pattern p is judged at edge 2p+3, so a fault-free run ends at t=34.
  int t = 0;

  function automatic logic [3:0] fm_upto(input int tt);
    logic [3:0] m;
    m = '0;
    for (int p = 0; p < NUM_PAT; p++)
      for (int k = 0; k < NUM_BLK; k++)
        if (2 * p + 3 <= tt && blk_bad[k][p]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic int final_t();
    return ($countones(fm_upto(1000)) == 1) ? 67 : 34;
  endfunction

  always @(posedge clk) begin
    if (init)                                        t <= 0;
    else if (start && (t == 0 || t >= final_t()))    t <= 1;
    else if (t > 0 && t < 1000)                      t <= t + 1;
  end

  function automatic logic [18:0] exp_vec(input int tt);
    logic [3:0] fm_full, fm, td, ssv;
    logic [2:0] isv;
    logic       tst, bsy, dn, fl;
    int         pop, idx;
    fm_full = fm_upto(1000);
    pop = $countones(fm_full);
    idx = 0;
    for (int k = NUM_BLK - 1; k >= 0; k--) if (fm_full[k]) idx = k;
    {tst, bsy, dn, fl} = '0;
    td = '0; isv = '0; ssv = '0; fm = '0;
    if (tt == 0) begin
    end else if (tt <= 32) begin
      tst = 1'b1; bsy = 1'b1; td = 4'((tt - 1) / 2); fm = fm_upto(tt);
    end else if (tt == 33) begin
      bsy = 1'b1; fm = fm_full;
    end else begin
      fm = fm_full;
      if (pop == 0) dn = 1'b1;
      else if (pop >= 2) fl = 1'b1;
      else begin
        isv = 3'(idx + 1); ssv = fm_full;
        if (tt <= 65) begin
          tst = 1'b1; bsy = 1'b1; td = 4'((tt - 34) / 2);
        end else if (tt == 66) begin
          bsy = 1'b1;
        end else if (spare_bad != '0) begin
          fl = 1'b1; isv = '0; ssv = '0;
        end else begin
          dn = 1'b1;
        end
      end
    end
    return {tst, td, isv, ssv, fm, bsy, dn, fl};
  endfunction

  logic [18:0] got_vec;
  assign got_vec = {test, test_data, is, ss, fault_map, busy, done, fail};

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checks++;
      if (got_vec !== exp_vec(t)) begin
        errors++;
        $display("FAIL cycle_cmp t=%0d got=%h exp=%h", t, got_vec, exp_vec(t));
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cfg_reset(input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3,
                           input logic [15:0] sp, input int g);
    @(negedge clk);
    init = 1'b1;
    blk_bad[0] = b0; blk_bad[1] = b1; blk_bad[2] = b2; blk_bad[3] = b3;
    spare_bad = sp; glitch_blk = g;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
  endtask

  // Pulse start, then count edges (start edge = 1) until done or fail.
  task automatic run_wait(input int pa, input int pb, output int n);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!(done || fail) && n < 200) begin
      start = (n == pa || n == pb);
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    if (n >= 200) chk("run_timeout", n, -1);
  endtask

  int n;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    init = 1'b0;
    chk_en = 1'b1;
    chk("reset_outs", int'(got_vec), 0);

    // Fault-free pass
    run_wait(0, 0, n);
    chk("ff_latency", n, 34);
    chk("ff_done", int'({done, fail}), 2);
    chk("ff_fmap", int'(fault_map), 0);
    chk("ff_is_ss", int'({is, ss}), 0);

    // start while DONE begins a new run
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("redo_state", int'({done, busy, test, test_data}), 'b0110000);
    n = 1;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    chk("redo_latency", n, 34);

    // Block 2 wrong on pattern 5 only, repaired by the spare
    cfg_reset(16'h0, 16'h0, 16'h0020, 16'h0, 16'h0, -1);
    run_wait(0, 0, n);
    chk("rep_latency", n, 67);
    chk("rep_done", int'({done, fail}), 2);
    chk("rep_fmap", int'(fault_map), 'b0100);
    chk("rep_is", int'(is), 3);
    chk("rep_ss", int'(ss), 'b0100);

    // Same fault with start re-pulsed during RUN and VERIFY
    cfg_reset(16'h0, 16'h0, 16'h0020, 16'h0, 16'h0, -1);
    run_wait(10, 45, n);
    chk("repulse_latency", n, 67);
    chk("repulse_done", int'(done), 1);

    // Blocks 1 and 3 faulty: unrepairable
    cfg_reset(16'h0, 16'h0001, 16'h0, 16'h8000, 16'h0, -1);
    run_wait(0, 0, n);
    chk("dbl_latency", n, 34);
    chk("dbl_fail", int'({done, fail, test}), 'b010);
    chk("dbl_fmap", int'(fault_map), 'b1010);
    chk("dbl_is_ss", int'({is, ss}), 0);

    // Block 0 faulty and spare faulty: verify pass fails
    cfg_reset(16'h0010, 16'h0, 16'h0, 16'h0, 16'h0100, -1);
    run_wait(0, 0, n);
    chk("spare_latency", n, 67);
    chk("spare_fail", int'({done, fail}), 1);
    chk("spare_fmap", int'(fault_map), 'b0001);
    chk("spare_is_ss", int'({is, ss}), 0);

    // Glitch right after each pattern change must not be sampled
    cfg_reset(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1);
    run_wait(0, 0, n);
    chk("glitch_latency", n, 34);
    chk("glitch_fmap", int'(fault_map), 0);

    // init in the middle of RUN, then a fresh complete run
    cfg_reset(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, -1);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); init = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outs", int'(got_vec), 0);
    @(negedge clk); init = 1'b0;
    run_wait(0, 0, n);
    chk("midrst_latency", n, 34);
    chk("midrst_done", int'({done, fail}), 2);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1);
  end

endmodule
